// File: rtl/alsu_gen.sv
// Two-stage arithmetic/logic/shift unit. Stage 1 registers the operation;
// stage 2 produces out/out_valid, toggles leds on illegal ops, and counts errors.
module alsu_gen #(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [2:0]             opcode,
  input  logic                   cin,
  input  logic                   serial_in,
  input  logic                   direction,
  input  logic                   red_op_A,
  input  logic                   red_op_B,
  input  logic                   bypass_A,
  input  logic                   bypass_B,
  output logic [2*WIDTH-1:0]     out,
  output logic                   out_valid,
  output logic [LED_WIDTH-1:0]   leds,
  output logic [7:0]             err_cnt
);
  localparam int   OW      = 2 * WIDTH;
  localparam logic PRIO_A  = (INPUT_PRIORITY == "A");
  localparam logic USE_CIN = (FULL_ADDER == "ON");

  // Valid semantics: in_valid marks a one-cycle operation with no backpressure;
  // out_valid pulses for exactly one cycle per accepted, non-flushed operation.
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_cin, r_s1_si, r_s1_dir;
  logic             r_s1_ra, r_s1_rb, r_s1_ba, r_s1_bb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_op  <= '0;
      r_s1_cin <= 1'b0;
      r_s1_si  <= 1'b0;
      r_s1_dir <= 1'b0;
      r_s1_ra  <= 1'b0;
      r_s1_rb  <= 1'b0;
      r_s1_ba  <= 1'b0;
      r_s1_bb  <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_a   <= A;
        r_s1_b   <= B;
        r_s1_op  <= opcode;
        r_s1_cin <= cin;
        r_s1_si  <= serial_in;
        r_s1_dir <= direction;
        r_s1_ra  <= red_op_A;
        r_s1_rb  <= red_op_B;
        r_s1_ba  <= bypass_A;
        r_s1_bb  <= bypass_B;
      end
    end
  end

  logic             w_invalid;
  logic             w_bypass;
  logic [WIDTH-1:0] w_byp_sel;
  logic [WIDTH-1:0] w_red_sel;
  logic [WIDTH:0]   w_sum;
  logic [OW-1:0]    w_prod;
  logic [OW-1:0]    w_result;

  // Reduction selects are only meaningful for the AND/XOR opcodes.
  assign w_invalid = (r_s1_op[2:1] == 2'b11) ||
                     ((r_s1_ra || r_s1_rb) && (r_s1_op[2:1] != 2'b00));
  assign w_bypass  = r_s1_ba || r_s1_bb;
  assign w_byp_sel = (r_s1_ba && r_s1_bb) ? (PRIO_A ? r_s1_a : r_s1_b)
                                          : (r_s1_ba ? r_s1_a : r_s1_b);
  assign w_red_sel = (r_s1_ra && r_s1_rb) ? (PRIO_A ? r_s1_a : r_s1_b)
                                          : (r_s1_ra ? r_s1_a : r_s1_b);
  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, (USE_CIN & r_s1_cin)};
  assign w_prod = {{WIDTH{1'b0}}, r_s1_a} * {{WIDTH{1'b0}}, r_s1_b};

  always_comb begin
    w_result = '0;
    if (w_bypass) begin
      w_result = {{WIDTH{1'b0}}, w_byp_sel};
    end else begin
      case (r_s1_op)
        3'b000: w_result = (r_s1_ra || r_s1_rb) ? {{(OW-1){1'b0}}, &w_red_sel}
                                                : {{WIDTH{1'b0}}, r_s1_a & r_s1_b};
        3'b001: w_result = (r_s1_ra || r_s1_rb) ? {{(OW-1){1'b0}}, ^w_red_sel}
                                                : {{WIDTH{1'b0}}, r_s1_a ^ r_s1_b};
        3'b010: w_result = {{(WIDTH-1){1'b0}}, w_sum};
        3'b011: w_result = w_prod;
        3'b100: w_result = r_s1_dir ? {out[OW-2:0], r_s1_si} : {r_s1_si, out[OW-1:1]};
        3'b101: w_result = r_s1_dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
        default: w_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      leds      <= '0;
      err_cnt   <= '0;
    end else if (r_s1_vld) begin
      out_valid <= 1'b1;
      if (w_invalid) begin
        out  <= '0;
        leds <= ~leds;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else begin
        out  <= w_result;
        leds <= '0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alsu_gen.sv
// Bench for alsu_gen (WIDTH=4): directed literal checks plus random traffic
// compared every cycle against a transaction-level model of two instances.
module tb_alsu_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [2:0] opcode = '0;
  logic       cin = 0, si = 0, dir = 0, ra = 0, rb = 0, ba = 0, bb = 0;

  logic [7:0]  out0, out1;
  logic        ov0, ov1;
  logic [15:0] leds0, leds1;
  logic [7:0]  err0, err1;

  always #5 clk = ~clk;

  alsu_gen #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .opcode(opcode),
    .cin(cin), .serial_in(si), .direction(dir), .red_op_A(ra), .red_op_B(rb),
    .bypass_A(ba), .bypass_B(bb), .out(out0), .out_valid(ov0), .leds(leds0),
    .err_cnt(err0));

  alsu_gen #(.WIDTH(4), .FULL_ADDER("OFF")) u_off (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .opcode(opcode),
    .cin(cin), .serial_in(si), .direction(dir), .red_op_A(ra), .red_op_B(rb),
    .bypass_A(ba), .bypass_B(bb), .out(out1), .out_valid(ov1), .leds(leds1),
    .err_cnt(err1));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] a, b;
    logic [2:0] opc;
    logic cin, si, dir, ra, rb, ba, bb;
  } op_t;

  op_t         op_q[$];
  int          m_out[2]  = '{0, 0};
  int          m_leds[2] = '{0, 0};
  int          m_err[2]  = '{0, 0};
  bit          m_vld = 0;

  function automatic bit is_invalid(op_t o);
    return (o.opc >= 6) || ((o.ra || o.rb) && o.opc > 1);
  endfunction

  function automatic int calc(op_t o, int cur, bit fa);
    int sel;
    if (o.ba || o.bb) return (o.ba && o.bb) ? o.a : (o.ba ? o.a : o.b);
    sel = (o.ra && o.rb) ? o.a : (o.ra ? o.a : o.b);
    case (o.opc)
      0: return (o.ra || o.rb) ? ((sel == 15) ? 1 : 0) : (o.a & o.b);
      1: return (o.ra || o.rb) ? ($countones(sel[3:0]) % 2) : (o.a ^ o.b);
      2: return o.a + o.b + ((fa && o.cin) ? 1 : 0);
      3: return o.a * o.b;
      4: return o.dir ? (((cur * 2) + o.si) % 256) : ((cur / 2) + (o.si ? 128 : 0));
      5: return o.dir ? (((cur * 2) % 256) + (cur / 128)) : ((cur / 2) + ((cur % 2) * 128));
      default: return 0;
    endcase
  endfunction

  // Each accepted op is retired one edge after capture.
  always @(posedge clk) begin
    op_t cur_op;
    if (rst) begin
      op_q.delete();
      m_vld = 0;
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 0; m_leds[i] = 0; m_err[i] = 0;
      end
    end else begin
      m_vld = (op_q.size() > 0);
      if (m_vld) begin
        cur_op = op_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          if (is_invalid(cur_op)) begin
            m_out[i]  = 0;
            m_leds[i] = m_leds[i] ^ 16'hFFFF;
            if (m_err[i] < 255) m_err[i]++;
          end else begin
            m_out[i]  = calc(cur_op, m_out[i], (i == 0));
            m_leds[i] = 0;
          end
        end
      end
      if (in_valid) op_q.push_back('{a, b, opcode, cin, si, dir, ra, rb, ba, bb});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out0",  out0,  m_out[0]);
      chk("m_vld0",  ov0,   m_vld);
      chk("m_leds0", leds0, m_leds[0]);
      chk("m_err0",  err0,  m_err[0]);
      chk("m_out1",  out1,  m_out[1]);
      chk("m_vld1",  ov1,   m_vld);
      chk("m_leds1", leds1, m_leds[1]);
      chk("m_err1",  err1,  m_err[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                      input logic tcin, input logic tsi, input logic tdir,
                      input logic tra, input logic trb, input logic tba, input logic tbb);
    @(negedge clk);
    a = ta; b = tb; opcode = top; cin = tcin; si = tsi; dir = tdir;
    ra = tra; rb = trb; ba = tba; bb = tbb; in_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_out", out0, 0);
    chk("rst_vld", ov0, 0);
    chk("rst_leds", leds0, 0);
    chk("rst_err", err0, 0);
    rst = 1'b0;

    send(4'hF, 4'h3, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("mul_no_early_vld", ov0, 0);
    idle();
    chk("mul_out", out0, 8'h2D);
    chk("mul_vld", ov0, 1);
    idle();
    chk("vld_pulse", ov0, 0);

    send(4'hF, 4'hF, 3'b010, 1, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    chk("add_fa_on", out0, 8'h1F);
    chk("add_fa_off", out1, 8'h1E);

    send(4'hF, 4'h3, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    send(4'h0, 4'h0, 3'b100, 0, 1, 1, 0, 0, 0, 0);
    send(4'h0, 4'h0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
    chk("mul_again", out0, 8'h2D);
    idle();
    chk("shl_si1", out0, 8'h5B);
    idle();
    chk("ror", out0, 8'hAD);

    send(4'h1, 4'h2, 3'b110, 0, 0, 0, 0, 0, 0, 0);
    send(4'h1, 4'h2, 3'b110, 0, 0, 0, 0, 0, 0, 0);
    send(4'h1, 4'h2, 3'b110, 0, 0, 0, 0, 0, 0, 0);
    chk("inv1_leds", leds0, 16'hFFFF);
    chk("inv1_out", out0, 0);
    idle();
    chk("inv2_leds", leds0, 16'h0000);
    idle();
    chk("inv3_leds", leds0, 16'hFFFF);
    chk("inv3_out", out0, 0);
    chk("inv3_err", err0, 3);
    send(4'h6, 4'h3, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    chk("valid_clears_leds", leds0, 0);
    chk("and_out", out0, 8'h02);

    send(4'h9, 4'h6, 3'b110, 0, 0, 0, 0, 0, 1, 1);
    idle(); idle();
    chk("inv_over_bypass_out", out0, 0);
    chk("inv_over_bypass_leds", leds0, 16'hFFFF);
    send(4'h9, 4'h6, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    idle(); idle();
    chk("bypass_prio_a", out0, 8'h09);
    chk("red_xor_pin", 32'(calc('{4'h7, 4'h0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 0, 1)), 1);

    send(4'hF, 4'h3, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("flush_vld", ov0, 0);
    chk("flush_out", out0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("flush_no_late_vld", ov0, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      opcode = 3'($urandom_range(0, 7));
      cin = 1'($urandom_range(0, 1));
      si  = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0);
      rb  = ($urandom_range(0, 3) == 0);
      ba  = ($urandom_range(0, 4) == 0);
      bb  = ($urandom_range(0, 4) == 0);
      rst = (i < 1000) && ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_saturated", err0, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alsu_gen.md
ALSU_GEN -- requirements
Module: alsu_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..16).
REQ-002 SHALL have parameter INPUT_PRIORITY, default "A", operand used when both bypass or both reduction selects are set ("A" or "B").
REQ-003 SHALL have parameter FULL_ADDER, default "ON", which includes cin in addition when "ON" and ignores it when "OFF".
REQ-004 SHALL have parameter LED_WIDTH, default 16, LED bus width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, qualifies all operation inputs this cycle.
REQ-008 SHALL have ports A and B, input, WIDTH each, operands.
REQ-009 SHALL have port opcode, input, 3, operation select.
REQ-010 SHALL have ports cin, serial_in, direction, red_op_A, red_op_B, bypass_A and bypass_B, input, 1 each, with the meanings given under Function.
REQ-011 SHALL have port out, output, 2*WIDTH, registered result.
REQ-012 SHALL have port out_valid, output, 1, one-cycle pulse marking a new out value.
REQ-013 SHALL have port leds, output, LED_WIDTH, error indicator.
REQ-014 SHALL have port err_cnt, output, 8, saturating count of invalid operations.

Function
REQ-015 SHALL capture all operation inputs into a stage-1 register on each edge where in_valid=1; the stage-1 valid bit SHALL be loaded with in_valid every cycle.
REQ-016 SHALL update out, out_valid, leds and err_cnt only from stage-1 contents; latency from in_valid to out_valid SHALL be exactly 2 edges, with full throughput (one operation per cycle).
REQ-017 SHALL hold out, leds and err_cnt unchanged, and drive out_valid=0, when the stage-1 valid bit is 0.
REQ-018 SHALL treat an operation as invalid when opcode is 110 or 111, or when (red_op_A|red_op_B)=1 and opcode is not 000 or 001.
REQ-019 SHALL apply precedence invalid > bypass > opcode.
REQ-020 On invalid: out<=0, leds<=~leds, err_cnt<=err_cnt+1 saturating at 255, out_valid<=1.
REQ-021 On valid: leds<=0.
REQ-022 Bypass: both set selects the operand per INPUT_PRIORITY; bypass_A alone selects A; bypass_B alone selects B; the selected operand is zero-extended to 2*WIDTH.
REQ-023 Opcode 000: reduction AND of the selected operand when red_op is set (both set resolved per INPUT_PRIORITY), else bitwise A&B; zero-extended.
REQ-024 Opcode 001: same as 000 using XOR.
REQ-025 Opcode 010: A+B(+cin per FULL_ADDER); the carry SHALL be kept in bit WIDTH.
REQ-026 Opcode 011: full unsigned product A*B over 2*WIDTH bits.
REQ-027 Opcode 100: shift of current out; direction=1 gives {out[2W-2:0],serial_in}; direction=0 gives {serial_in,out[2W-1:1]}.
REQ-028 Opcode 101: rotate of current out; direction=1 rotates left; direction=0 rotates right.
REQ-029 Shift and rotate SHALL use out as it stands before the edge, including back-to-back shift or rotate ops on consecutive cycles.

Reset
REQ-030 rst=1 at an edge SHALL clear the stage-1 registers and stage-1 valid bit, and set out=0, out_valid=0, leds=0 and err_cnt=0.
REQ-031 rst SHALL take priority over in_valid on the same edge.
REQ-032 An operation in flight SHALL be discarded by reset and SHALL produce no out_valid.
REQ-033 The first operation accepted after rst is released SHALL follow the normal 2-edge latency.

Verification (WIDTH=4, defaults)
REQ-034 A=F, B=3, opcode=011, in_valid pulse -> out=0x2D with out_valid=1 exactly 2 edges later.
REQ-035 A=F, B=F, cin=1, opcode=010 -> out=0x1F; same with FULL_ADDER="OFF" -> out=0x1E.
REQ-036 opcode=110 on 3 consecutive cycles -> leds FFFF, 0000, FFFF; out=0; err_cnt=3; a following valid op -> leds=0000.
REQ-037 From out=0x2D: opcode=100, direction=1, serial_in=1 -> 0x5B; next opcode=101, direction=0 -> 0xAD.
REQ-038 bypass_A=bypass_B=1, A=9, B=6, opcode=110 -> out=0, leds toggle (invalid wins); same inputs with opcode=000 -> out=0x09.
REQ-039 in_valid at edge N, rst=1 at edge N+1 -> no out_valid at N+2; out=0.
